// File: rtl/divu_seq_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// Handshake: start is a request sampled on a rising edge; it is accepted only
// while busy is low (idle or in the done cycle), and done pulses for one cycle
// when q/r/div_zero are valid. Results then hold until the next accepted start.
interface divu_seq_if;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, dividend, divisor,
        input  q, r, busy, done, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output q, r, busy, done, div_zero
    );
endinterface

// File: rtl/divu_seq.sv
// 32-bit unsigned restoring divider, one quotient bit per clock, for the DIVU path.
// Quotient lands on q (LO), remainder on r (HI); both hold until the next accepted start.
module divu_seq (
    input  logic       clk,
    input  logic       reset,
    divu_seq_if.slave  bus,
    output logic [1:0] dbg_state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] dq_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [31:0] q_q;
    logic [31:0] r_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;

    logic [32:0] shifted_d;
    logic [32:0] trial_d;
    logic [31:0] rem_d;
    logic [31:0] dq_d;
    logic        accept_d;

    // The partial remainder stays below the divisor, so 32 stored bits suffice;
    // the 33rd bit only exists transiently in the shifted/trial values.
    always_comb begin
        shifted_d = {rem_q, dq_q[31]};
        trial_d   = shifted_d - {1'b0, dvs_q};
        rem_d     = trial_d[32] ? shifted_d[31:0] : trial_d[31:0];
        dq_d      = {dq_q[30:0], ~trial_d[32]};
    end

    assign accept_d = bus.start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            dq_q    <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else if (accept_d) begin
            dq_q    <= bus.dividend;
            dvs_q   <= bus.divisor;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= (bus.divisor != 32'd0);
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    // A zero divisor spends one non-busy cycle here so its done
                    // pulse arrives one edge after acceptance.
                    if (dvs_q == 32'd0) begin
                        q_q     <= '1;
                        r_q     <= dq_q;
                        dz_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rem_q <= rem_d;
                        dq_q  <= dq_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            q_q     <= dq_d;
                            r_q     <= rem_d;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q        = q_q;
    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq: hand-computed quotients/remainders, latency,
// busy length, divide-by-zero, ignored start, back-to-back and mid-op reset.
module tb_divu_seq;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    divu_seq_if bus ();

    divu_seq dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done, checking latency, busy length and results.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edz, input int elat, input int ebusy,
                         input string tag);
        int lat;
        int bcnt;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        edge1();
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 40) begin
            bcnt += int'(bus.busy);
            edge1();
            lat++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy_cycles"}, bcnt, ebusy);
        chk({tag, "_q"}, bus.q, eq);
        chk({tag, "_r"}, bus.r, er);
        chk({tag, "_dz"}, bus.div_zero, edz);
        chk({tag, "_state_done"}, dbg_state, 2'd2);
        edge1();
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
        chk({tag, "_hold_q"}, bus.q, eq);
        chk({tag, "_hold_r"}, bus.r, er);
        chk({tag, "_hold_dz"}, bus.div_zero, edz);
        chk({tag, "_state_idle"}, dbg_state, 2'd0);
    endtask

    initial begin
        int lat;
        total        = 0;
        bad          = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", bus.q, 32'd0);
        chk("rst_r", bus.r, 32'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_dz", bus.div_zero, 1'b0);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        edge1();

        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 32, "basic_100_7");
        do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32, 32, "max_div_1");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 32, 32, "msb_div_max");
        do_op(32'd3, 32'h8000_0000, 32'd0, 32'd3, 1'b0, 32, 32, "small_div_msb");
        do_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, "div_zero");
        do_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, 32, "after_zero_9_3");

        // start pulse at E10 carrying 7/7 must be ignored
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        edge1();
        bus.start = 1'b0;
        repeat (9) edge1();
        bus.start    = 1'b1;
        bus.dividend = 32'd7;
        bus.divisor  = 32'd7;
        edge1();
        bus.start = 1'b0;
        lat = 10;
        while (!bus.done && lat < 40) begin
            edge1();
            lat++;
        end
        chk("ignore_lat", lat, 32);
        chk("ignore_q", bus.q, 32'd100);
        chk("ignore_r", bus.r, 32'd0);
        edge1();
        chk("ignore_no_requeue", bus.busy, 1'b0);

        // back-to-back: start held through the DONE cycle
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd6;
        edge1();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            edge1();
            lat++;
        end
        chk("b2b_first_lat", lat, 32);
        chk("b2b_first_q", bus.q, 32'd8);
        chk("b2b_first_r", bus.r, 32'd2);
        bus.start    = 1'b1;
        bus.dividend = 32'd81;
        bus.divisor  = 32'd9;
        edge1();
        bus.start = 1'b0;
        chk("b2b_accept_busy", bus.busy, 1'b1);
        chk("b2b_accept_done", bus.done, 1'b0);
        chk("b2b_q_held_during_run", bus.q, 32'd8);
        lat = 0;
        while (!bus.done && lat < 40) begin
            edge1();
            lat++;
        end
        chk("b2b_second_lat", lat, 32);
        chk("b2b_second_q", bus.q, 32'd9);
        chk("b2b_second_r", bus.r, 32'd0);
        repeat (5) edge1();
        chk("b2b_hold_q", bus.q, 32'd9);
        chk("b2b_hold_r", bus.r, 32'd0);
        chk("b2b_hold_state", dbg_state, 2'd0);

        // reset asserted between edges during E15 of 12345/67
        bus.start    = 1'b1;
        bus.dividend = 32'd12345;
        bus.divisor  = 32'd67;
        edge1();
        bus.start = 1'b0;
        repeat (15) edge1();
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_q", bus.q, 32'd0);
        chk("midrst_r", bus.r, 32'd0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_dz", bus.div_zero, 1'b0);
        chk("midrst_state", dbg_state, 2'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_op(32'd12345, 32'd67, 32'd184, 32'd17, 1'b0, 32, 32, "after_rst_12345_67");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
